// File: rtl/pkt_sched.sv
// Packet scheduler: arbitrates NUM_PRI head-of-queue inputs (strict or round-robin)
// and forwards whole packets word by word through a single registered output stage.
module pkt_sched #(
    parameter int DATA_W  = 64,
    parameter int NUM_PRI = 8,
    parameter int IDX_W   = 3
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      mode,
    input  logic [NUM_PRI-1:0]        q_ready,
    input  logic [NUM_PRI-1:0]        q_sop,
    input  logic [NUM_PRI-1:0]        q_eop,
    input  logic [NUM_PRI-1:0]        q_vld,
    input  logic [NUM_PRI*DATA_W-1:0] q_data,
    output logic [NUM_PRI-1:0]        q_next,
    input  logic                      out_rdy,
    output logic                      out_sop,
    output logic                      out_eop,
    output logic                      out_vld,
    output logic [DATA_W-1:0]         out_data,
    output logic [IDX_W-1:0]          grant_idx,
    output logic                      busy,
    output logic [15:0]               pkt_cnt,
    output logic                      sop_err
);

    typedef enum logic {IDLE = 1'b0, XFER = 1'b1} state_t;

    state_t             state;
    state_t             state_nxt;
    logic [IDX_W-1:0]   rr_ptr;
    logic [IDX_W-1:0]   win_idx;
    logic               win_vld;
    logic               arb_mode;
    logic               first_word;
    logic               free;
    logic               pop;
    logic               pop_sop;
    logic               pop_eop;
    logic [DATA_W-1:0]  pop_data;
    logic               unused_vld;

    // Head-word valid flags duplicate q_ready and carry no extra meaning here.
    assign unused_vld = ^q_vld;

    // Winner for the next arbitration. Round-robin scans offsets from the far end
    // down so the smallest offset past rr_ptr is the last (and kept) assignment.
    always_comb begin
        int k;
        win_idx = '0;
        win_vld = 1'b0;
        k       = 0;
        if (!mode) begin
            for (int i = 0; i < NUM_PRI; i++) begin
                if (q_ready[i]) begin
                    win_idx = IDX_W'(i);
                    win_vld = 1'b1;
                end
            end
        end else begin
            for (int off = NUM_PRI; off >= 1; off--) begin
                k = (int'(rr_ptr) + off) % NUM_PRI;
                if (q_ready[k]) begin
                    win_idx = IDX_W'(k);
                    win_vld = 1'b1;
                end
            end
        end
    end

    // Handshake: a word moves from queue grant_idx into the output register in any
    // XFER cycle where that queue is ready and the register is free (empty, or its
    // word is being taken by out_rdy this same cycle); q_next is that pop strobe.
    assign free     = !out_vld || out_rdy;
    assign pop      = rst && (state == XFER) && q_ready[grant_idx] && free;
    assign pop_sop  = q_sop[grant_idx];
    assign pop_eop  = q_eop[grant_idx];
    assign pop_data = q_data[int'(grant_idx)*DATA_W +: DATA_W];

    always_ff @(posedge clk) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (win_vld) state_nxt = XFER;
            XFER:    if (pop && pop_eop) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        q_next = '0;
        busy   = (state == XFER);
        if (pop) begin
            q_next[grant_idx] = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            grant_idx  <= '0;
            rr_ptr     <= IDX_W'(NUM_PRI - 1);
            arb_mode   <= 1'b0;
            first_word <= 1'b0;
            out_sop    <= 1'b0;
            out_eop    <= 1'b0;
            out_vld    <= 1'b0;
            out_data   <= '0;
            pkt_cnt    <= '0;
            sop_err    <= 1'b0;
        end else begin
            if (state == IDLE && win_vld) begin
                grant_idx  <= win_idx;
                arb_mode   <= mode;
                first_word <= 1'b1;
            end
            if (pop) begin
                out_sop    <= pop_sop;
                out_eop    <= pop_eop;
                out_data   <= pop_data;
                out_vld    <= 1'b1;
                first_word <= 1'b0;
                // Framing is wrong whenever sop disagrees with "first word of grant".
                if (first_word ^ pop_sop) begin
                    sop_err <= 1'b1;
                end
                if (pop_eop) begin
                    pkt_cnt <= pkt_cnt + 16'd1;
                    if (arb_mode) begin
                        rr_ptr <= grant_idx;
                    end
                end
            end else if (out_vld && out_rdy) begin
                out_vld <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_pkt_sched.sv
// Bench for pkt_sched: directed scenarios plus randomized packet mixes checked
// against a packet-level scheduling model and an expected output word queue.
module tb_pkt_sched;

    localparam int DATA_W  = 64;
    localparam int NUM_PRI = 8;
    localparam int IDX_W   = 3;
    localparam int MAXW    = 64;
    localparam int MAXP    = 16;

    logic                      clk;
    logic                      rst;
    logic                      mode;
    logic [NUM_PRI-1:0]        q_ready;
    logic [NUM_PRI-1:0]        q_sop;
    logic [NUM_PRI-1:0]        q_eop;
    logic [NUM_PRI-1:0]        q_vld;
    logic [NUM_PRI*DATA_W-1:0] q_data;
    logic [NUM_PRI-1:0]        q_next;
    logic                      out_rdy;
    logic                      out_sop;
    logic                      out_eop;
    logic                      out_vld;
    logic [DATA_W-1:0]         out_data;
    logic [IDX_W-1:0]          grant_idx;
    logic                      busy;
    logic [15:0]               pkt_cnt;
    logic                      sop_err;

    pkt_sched #(.DATA_W(DATA_W), .NUM_PRI(NUM_PRI), .IDX_W(IDX_W)) dut (
        .clk(clk), .rst(rst), .mode(mode),
        .q_ready(q_ready), .q_sop(q_sop), .q_eop(q_eop), .q_vld(q_vld), .q_data(q_data),
        .q_next(q_next), .out_rdy(out_rdy),
        .out_sop(out_sop), .out_eop(out_eop), .out_vld(out_vld), .out_data(out_data),
        .grant_idx(grant_idx), .busy(busy), .pkt_cnt(pkt_cnt), .sop_err(sop_err)
    );

    // Clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #3000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    int checks = 0;
    int errors = 0;

    // Source queues: {sop, eop, data} per word, read pointer advanced on q_next.
    logic [DATA_W+1:0]  mem     [NUM_PRI][MAXW];
    bit                 first_w [NUM_PRI][MAXW];
    int                 rd      [NUM_PRI];
    int                 wr      [NUM_PRI];
    int                 plen    [NUM_PRI][MAXP];
    int                 pn      [NUM_PRI];
    bit                 gate    [NUM_PRI];
    logic [DATA_W+2:0]  exp_q[$];   // {sop_err after load, sop, eop, data}
    bit                 model_err;
    int                 model_pkts;

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic clear_sources();
        for (int k = 0; k < NUM_PRI; k++) begin
            rd[k] = 0; wr[k] = 0; pn[k] = 0; gate[k] = 1'b0;
        end
    endtask

    task automatic add_pkt(input int q, input int len, input bit bad_first, input int mid_pct);
        logic s;
        for (int w = 0; w < len; w++) begin
            s = (w == 0) ? !bad_first : ($urandom_range(99) < mid_pct);
            mem[q][wr[q]] = {s, (w == len - 1), 8'(q), 8'(pn[q]), 8'(w), 40'($urandom)};
            first_w[q][wr[q]] = (w == 0);
            wr[q]++;
        end
        plen[q][pn[q]] = len;
        pn[q]++;
    endtask

    // Packet-level schedule: whole packets in arbitration order; every source with
    // packets left is ready at arbitration time.
    task automatic model(input bit m);
        int mpos [NUM_PRI];
        int np   [NUM_PRI];
        int ptr;
        int win;
        int k;
        logic [DATA_W+1:0] word;
        exp_q.delete();
        ptr = NUM_PRI - 1;
        model_err = 1'b0;
        model_pkts = 0;
        for (int i = 0; i < NUM_PRI; i++) begin
            mpos[i] = 0; np[i] = 0;
        end
        forever begin
            win = -1;
            if (!m) begin
                for (int i = 0; i < NUM_PRI; i++) if (np[i] < pn[i]) win = i;
            end else begin
                for (int off = 1; off <= NUM_PRI; off++) begin
                    k = (ptr + off) % NUM_PRI;
                    if (win < 0 && np[k] < pn[k]) win = k;
                end
            end
            if (win < 0) break;
            for (int w = 0; w < plen[win][np[win]]; w++) begin
                word = mem[win][mpos[win] + w];
                if (word[DATA_W+1] != (w == 0)) model_err = 1'b1;
                exp_q.push_back({model_err, word});
            end
            mpos[win] += plen[win][np[win]];
            np[win]++;
            model_pkts++;
            if (m) ptr = win;
        end
    endtask

    task automatic drive();
        logic [DATA_W+1:0] w;
        q_ready = '0; q_sop = '0; q_eop = '0; q_vld = '0; q_data = '0;
        for (int k = 0; k < NUM_PRI; k++) begin
            if (rd[k] < wr[k]) begin
                w = mem[k][rd[k]];
                q_vld[k] = 1'b1;
                q_sop[k] = w[DATA_W+1];
                q_eop[k] = w[DATA_W];
                q_data[k*DATA_W +: DATA_W] = w[DATA_W-1:0];
                q_ready[k] = !gate[k];
            end
        end
    endtask

    task automatic reset_dut();
        rst = 1'b0;
        out_rdy = 1'b0;
        clear_sources();
        drive();
        repeat (2) @(posedge clk);
        #1 rst = 1'b1;
    endtask

    // Driver + monitor: one iteration per clock; outputs sampled on the negedge.
    task automatic run_sched(input bit m, input int rdy_pct, input bit rdy_toggle,
                             input int starve_pct, input int sq, input int s_at,
                             input int s_len, input int max_cyc, output int last_cyc);
        bit done;
        bit s_done;
        int popped;
        int acc_eop;
        int s_left;
        logic [DATA_W+2:0] e;
        mode = m;
        model(m);
        acc_eop = 0; done = 1'b0; s_done = 1'b0; s_left = 0; last_cyc = -1;
        for (int k = 0; k < NUM_PRI; k++) gate[k] = 1'b0;
        out_rdy = rdy_toggle ? 1'b1 : ($urandom_range(99) < rdy_pct);
        drive();
        for (int c = 0; c < max_cyc && !done; c++) begin
            @(negedge clk);
            popped = -1;
            if (q_next != '0) begin
                check("q_next_onehot", $countones(q_next), 1);
                check("q_next_while_stalled", out_vld && !out_rdy, 0);
                for (int k = 0; k < NUM_PRI; k++) if (q_next[k]) popped = k;
                check("q_next_ready", q_ready[popped], 1);
            end
            if (s_left > 0) check("starve_no_pop", q_next, 0);
            if (out_vld && out_rdy) begin
                if (exp_q.size() == 0) begin
                    check("extra_word", out_vld, 0);
                end else begin
                    e = exp_q.pop_front();
                    check("out_data", out_data, e[DATA_W-1:0]);
                    check("out_sop", out_sop, e[DATA_W+1]);
                    check("out_eop", out_eop, e[DATA_W]);
                    if (e[DATA_W]) acc_eop++;
                    check("pkt_cnt", pkt_cnt, acc_eop);
                    check("sop_err", sop_err, e[DATA_W+2]);
                    if (exp_q.size() == 0) begin
                        done = 1'b1;
                        last_cyc = c;
                    end
                end
            end
            @(posedge clk);
            #1;
            if (popped >= 0) rd[popped]++;
            if (s_left > 0) s_left--;
            if (!s_done && sq >= 0 && rd[sq] == s_at) begin
                s_left = s_len;
                s_done = 1'b1;
            end
            for (int k = 0; k < NUM_PRI; k++) begin
                gate[k] = (rd[k] < wr[k]) && !first_w[k][rd[k]] && ($urandom_range(99) < starve_pct);
                if (k == sq && s_left > 0) gate[k] = 1'b1;
            end
            out_rdy = rdy_toggle ? !out_rdy : ($urandom_range(99) < rdy_pct);
            drive();
        end
        check("run_complete", done, 1);
        check("exp_drained", exp_q.size(), 0);
    endtask

    initial begin
        int lc;
        int n;
        rst = 1'b0; mode = 1'b0; out_rdy = 1'b0;
        clear_sources();
        drive();

        // Reset state, with a queue ready so q_next gating is visible
        repeat (2) @(posedge clk);
        #1;
        add_pkt(3, 2, 1'b0, 0);
        out_rdy = 1'b1;
        drive();
        @(negedge clk);
        check("rst_q_next", q_next, 0);
        check("rst_out_vld", out_vld, 0);
        check("rst_out_sop", out_sop, 0);
        check("rst_out_eop", out_eop, 0);
        check("rst_out_data", out_data, 0);
        check("rst_grant_idx", grant_idx, 0);
        check("rst_busy", busy, 0);
        check("rst_pkt_cnt", pkt_cnt, 0);
        check("rst_sop_err", sop_err, 0);

        // Strict priority: queue 7 before queue 1, full throughput
        reset_dut();
        add_pkt(7, 3, 1'b0, 0);
        add_pkt(1, 3, 1'b0, 0);
        run_sched(1'b0, 100, 1'b0, 0, -1, 0, 0, 200, lc);
        check("strict_throughput_cycles", lc, 8);
        check("strict_pkt_cnt", pkt_cnt, 2);

        // Round-robin over queues 0,3,5 with two single-word packets each
        reset_dut();
        for (int r = 0; r < 2; r++) begin
            add_pkt(0, 1, 1'b0, 0);
            add_pkt(3, 1, 1'b0, 0);
            add_pkt(5, 1, 1'b0, 0);
        end
        run_sched(1'b1, 100, 1'b0, 0, -1, 0, 0, 200, lc);
        check("rr_throughput_cycles", lc, 12);
        check("rr_pkt_cnt", pkt_cnt, 6);
        @(negedge clk);
        check("rr_idle_busy", busy, 0);

        // Backpressure: out_rdy toggling 1,0,1,0
        reset_dut();
        add_pkt(2, 4, 1'b0, 0);
        run_sched(1'b0, 100, 1'b1, 0, -1, 0, 0, 200, lc);
        check("bp_words_popped", rd[2], 4);
        check("bp_pkt_cnt", pkt_cnt, 1);

        // Mid-packet starvation of queue 2 while queue 6 waits
        reset_dut();
        add_pkt(2, 4, 1'b0, 0);
        add_pkt(6, 2, 1'b0, 0);
        run_sched(1'b1, 100, 1'b0, 0, 2, 2, 5, 200, lc);
        check("starve_pkt_cnt", pkt_cnt, 2);

        // Framing: missing sop on first word, then a clean packet; sticky until reset
        reset_dut();
        add_pkt(1, 2, 1'b1, 0);
        add_pkt(1, 1, 1'b0, 0);
        run_sched(1'b0, 100, 1'b0, 0, -1, 0, 0, 200, lc);
        check("framing_sticky", sop_err, 1);
        reset_dut();
        @(negedge clk);
        check("framing_cleared", sop_err, 0);
        add_pkt(4, 3, 1'b0, 100);
        run_sched(1'b0, 100, 1'b0, 0, -1, 0, 0, 200, lc);
        check("framing_mid_sop", sop_err, 1);

        // Randomized packet mixes
        for (int round = 0; round < 6; round++) begin
            reset_dut();
            for (int k = 0; k < NUM_PRI; k++) begin
                n = $urandom_range(0, 3);
                for (int p = 0; p < n; p++)
                    add_pkt(k, $urandom_range(1, 5), ($urandom_range(19) == 0), 3);
            end
            add_pkt($urandom_range(0, NUM_PRI - 1), $urandom_range(1, 5), 1'b0, 0);
            run_sched($urandom_range(0, 1), $urandom_range(40, 100), 1'b0, 30, -1, 0, 0, 3000, lc);
            check("rand_pkt_cnt", pkt_cnt, model_pkts);
            check("rand_sop_err", sop_err, model_err);
            @(negedge clk);
            check("rand_idle_busy", busy, 0);
        end

        // Reset one cycle after the second word of a packet
        reset_dut();
        add_pkt(4, 4, 1'b0, 0);
        mode = 1'b0;
        out_rdy = 1'b1;
        drive();
        for (int c = 0; c < 50 && rd[4] < 2; c++) begin
            @(negedge clk);
            n = q_next[4];
            @(posedge clk);
            #1;
            if (n != 0) rd[4]++;
            drive();
        end
        check("rst_mid_reached", rd[4], 2);
        rst = 1'b0;
        @(negedge clk);
        check("rst_mid_q_next", q_next, 0);
        clear_sources();
        drive();
        @(posedge clk);
        #1 rst = 1'b1;
        @(negedge clk);
        check("rst_mid_out_vld", out_vld, 0);
        check("rst_mid_busy", busy, 0);
        check("rst_mid_pkt_cnt", pkt_cnt, 0);
        check("rst_mid_q_next_after", q_next, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/pkt_sched.md
PKT_SCHED -- requirements
Module: pkt_sched

Interface
REQ-001 SHALL have parameter DATA_W, default 64, per-queue data word width.
REQ-002 SHALL have parameter NUM_PRI, default 8, number of priority queues; queue index NUM_PRI-1 is highest priority.
REQ-003 SHALL have parameter IDX_W, default 3, queue index width (2**IDX_W >= NUM_PRI).
REQ-004 clk  input  1  single clock; all state updates on posedge clk.
REQ-005 rst  input  1  reset, synchronous, active-low (rst==0 resets on posedge clk).
REQ-006 mode  input  1  0 = strict priority, 1 = round-robin.
REQ-007 q_ready  input  NUM_PRI  per-queue "word available" flag.
REQ-008 q_sop, q_eop, q_vld  input  NUM_PRI each  per-queue head-word flags.
REQ-009 q_data  input  NUM_PRI*DATA_W  per-queue head word; queue k at bits [k*DATA_W +: DATA_W].
REQ-010 q_next  output  NUM_PRI  per-queue pop strobe, combinational, at most one bit high.
REQ-011 out_rdy  input  1  downstream accepts out word this cycle.
REQ-012 out_sop, out_eop, out_vld  output  1 each  registered output word flags; out_vld marks word valid.
REQ-013 out_data  output  DATA_W  registered output word.
REQ-014 grant_idx  output  IDX_W  queue currently owning the output.
REQ-015 busy  output  1  high while in XFER.
REQ-016 pkt_cnt  output  16  packets completed (eop words loaded), wraps 0xFFFF->0.
REQ-017 sop_err  output  1  sticky framing error flag.

Function
REQ-018 FSM states SHALL be IDLE and XFER.
REQ-019 IDLE: if any q_ready bit high, SHALL register winner into grant_idx and enter XFER next cycle; else stay IDLE; q_next all 0 in IDLE.
REQ-020 Strict mode SHALL pick highest-index q_ready bit.
REQ-021 Round-robin mode SHALL search from (rr_ptr+1) mod NUM_PRI upward with wrap, first q_ready bit wins; rr_ptr resets to NUM_PRI-1 so queue 0 is searched first.
REQ-022 mode SHALL be sampled only in IDLE; changes during XFER take effect at next arbitration.
REQ-023 Output register free = !out_vld || out_rdy.
REQ-024 XFER: q_next[grant_idx] SHALL equal q_ready[grant_idx] && free; all other bits 0.
REQ-025 On q_next pulse, out_sop/eop/data SHALL load the granted queue's head word and out_vld SHALL be 1 next cycle (1-cycle pop-to-output latency).
REQ-026 When out_vld && out_rdy and no new load, out_vld SHALL clear next cycle.
REQ-027 Granted queue with q_ready low mid-packet SHALL stall: grant held, no pop, no other queue served.
REQ-028 Loading a word with q_eop=1 SHALL return FSM to IDLE next cycle, increment pkt_cnt, and (RR mode) set rr_ptr=grant_idx.
REQ-029 Packets SHALL never interleave; grant changes only in IDLE.
REQ-030 Sustained throughput SHALL be one word per cycle while q_ready and out_rdy stay high; one idle arbitration cycle between packets.
REQ-031 sop_err SHALL set if first loaded word of a grant has q_sop=0, or a later word of same grant has q_sop=1; words are still forwarded unchanged.
REQ-032 Single-word packet (sop and eop both 1) SHALL be legal: one pop, return to IDLE.
REQ-033 busy SHALL be 1 exactly when state is XFER.

Reset
REQ-034 On rst==0 at posedge clk: state=IDLE, grant_idx=0, rr_ptr=NUM_PRI-1, out_sop/eop/vld=0, out_data=0, pkt_cnt=0, sop_err=0, busy=0.
REQ-035 While rst==0, q_next SHALL be all 0; reset mid-packet abandons the packet with no further pops.

Verification
REQ-036 Strict: q_ready=8'b1000_0010 in IDLE, 3-word packets each, out_rdy=1 -> queue 7 packet out first, then queue 1; pkt_cnt=2.
REQ-037 RR: queues 0,3,5 each hold 2 one-word packets, mode=1 -> grant order 0,3,5,0,3,5; pkt_cnt=6.
REQ-038 Backpressure: 4-word packet, out_rdy toggling 1,0,1,0 -> out_data order preserved, no word dropped/duplicated, q_next never high while out_vld&&!out_rdy.
REQ-039 Mid-packet starvation: granted queue 2 drops q_ready after word 2 for 5 cycles while queue 6 ready -> no pop on 6 until queue 2 eop loaded.
REQ-040 Framing: first word of grant has q_sop=0 -> sop_err=1 next cycle, stays 1 until rst==0.
REQ-041 Reset mid-XFER: rst=0 one cycle after second word -> next cycle out_vld=0, busy=0, pkt_cnt=0, q_next=0.
